// File: rtl/branch_resolve_unit.sv
// Two-stage execute-stage branch resolver: evaluates the branch condition, target and link,
// flags mispredicts, raises a one-cycle fetch redirect and keeps taken/mispredict statistics.
module branch_resolve_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned BXXOP_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_branch,
  input  logic               in_is_jal,
  input  logic               in_is_jalr,
  input  logic [BXXOP_W-1:0] bxx_opcode,
  input  logic [XLEN-1:0]    src1,
  input  logic [XLEN-1:0]    src2,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    imm,
  input  logic               pred_taken,
  input  logic [XLEN-1:0]    pred_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_taken,
  output logic               out_mispredict,
  output logic [XLEN-1:0]    out_target,
  output logic [XLEN-1:0]    out_link,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [CNT_W-1:0]   taken_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  localparam int unsigned DIFF_W   = XLEN + 1;
  localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_MASK = ~XLEN'(1);

  // Operands and prediction captured at acceptance
  typedef struct packed {
    logic               is_branch;
    logic               is_jal;
    logic               is_jalr;
    logic [BXXOP_W-1:0] op;
    logic [XLEN-1:0]    src1;
    logic [XLEN-1:0]    src2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic               pred_taken;
    logic [XLEN-1:0]    pred_target;
  } s1_t;

  // Resolved results presented downstream
  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] redirect_pc;
  } s2_t;

  s1_t              s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  s2_t              s2_q, s2_d;
  logic             s2_valid_q, s2_valid_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic              retire_c, s1_adv_c, accept_c, s2_load_c;
  logic [DIFF_W-1:0] diff_c;
  logic              eq_c, lt_c, ltu_c, cmp_c, cond_c;
  logic              taken_c, mispredict_c;
  logic [XLEN-1:0]   jalr_sum_c, target_c, link_c, redir_pc_c;

  // Handshake: S1 moves on whenever S2 is empty or retiring
  assign retire_c  = s2_valid_q & out_ready;
  assign s1_adv_c  = ~s2_valid_q | retire_c;
  assign in_ready  = ~rst & ~redirect_q & (~s1_valid_q | s1_adv_c);
  assign accept_c  = in_valid & in_ready;
  assign s2_load_c = s1_valid_q & ~redirect_q & s1_adv_c;

  // Single subtractor feeds eq, signed-lt and unsigned-lt
  always_comb begin : compare
    diff_c = {1'b0, s1_q.src1} - {1'b0, s1_q.src2};
    eq_c   = (diff_c[XLEN-1:0] == '0);
    ltu_c  = diff_c[XLEN];
    lt_c   = (s1_q.src1[XLEN-1] & ~s1_q.src2[XLEN-1])
           | (~(s1_q.src1[XLEN-1] ^ s1_q.src2[XLEN-1]) & diff_c[XLEN-1]);
    case (s1_q.op[2:1])
      2'b00:   cmp_c = eq_c;
      2'b10:   cmp_c = lt_c;
      2'b11:   cmp_c = ltu_c;
      default: cmp_c = 1'b0;
    endcase
    cond_c = cmp_c ^ s1_q.op[0];
  end

  always_comb begin : resolve
    jalr_sum_c   = s1_q.src1 + s1_q.imm;
    target_c     = s1_q.is_jalr ? (jalr_sum_c & LSB_MASK) : (s1_q.pc + s1_q.imm);
    link_c       = s1_q.pc + LINK_OFS;
    taken_c      = s1_q.is_jal | s1_q.is_jalr | (s1_q.is_branch & cond_c);
    mispredict_c = (taken_c != s1_q.pred_taken)
                 | (taken_c & (target_c != s1_q.pred_target));
    redir_pc_c   = taken_c ? target_c : link_c;
  end

  // flush overrides capture, advance, redirect and statistics
  always_comb begin : next_state
    s1_valid_d    = s1_valid_q;
    s1_d          = s1_q;
    s2_valid_d    = s2_valid_q;
    s2_d          = s2_q;
    redirect_d    = 1'b0;
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept_c) begin
      s1_valid_d       = 1'b1;
      s1_d.is_branch   = in_is_branch;
      s1_d.is_jal      = in_is_jal;
      s1_d.is_jalr     = in_is_jalr;
      s1_d.op          = bxx_opcode;
      s1_d.src1        = src1;
      s1_d.src2        = src2;
      s1_d.pc          = pc;
      s1_d.imm         = imm;
      s1_d.pred_taken  = pred_taken;
      s1_d.pred_target = pred_target;
    end else if (redirect_q | s1_adv_c) begin
      s1_valid_d = 1'b0;
    end

    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_load_c) begin
      s2_valid_d       = 1'b1;
      s2_d.taken       = taken_c;
      s2_d.mispredict  = mispredict_c;
      s2_d.target      = target_c;
      s2_d.link        = link_c;
      s2_d.redirect_pc = redir_pc_c;
      redirect_d       = mispredict_c;
    end else if (retire_c) begin
      s2_valid_d = 1'b0;
    end

    if (retire_c & ~flush) begin
      taken_cnt_d   = taken_cnt_q + CNT_W'(s2_q.taken);
      mispred_cnt_d = mispred_cnt_q + CNT_W'(s2_q.mispredict);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= '0;
      s1_valid_q    <= 1'b0;
      s2_q          <= '0;
      s2_valid_q    <= 1'b0;
      redirect_q    <= 1'b0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      s1_q          <= s1_d;
      s1_valid_q    <= s1_valid_d;
      s2_q          <= s2_d;
      s2_valid_q    <= s2_valid_d;
      redirect_q    <= redirect_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_taken      = s2_q.taken;
  assign out_mispredict = s2_q.mispredict;
  assign out_target     = s2_q.target;
  assign out_link       = s2_q.link;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = s2_q.redirect_pc;
  assign taken_cnt      = taken_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, an in-order result
// queue model (mispredicts squash younger entries, flush/reset empty it) and literal pins.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        in_is_branch, in_is_jal, in_is_jalr;
  logic [2:0]  bxx_opcode;
  logic [31:0] src1, src2, pc, imm, pred_target;
  logic        pred_taken;
  logic        out_valid, out_ready, out_taken, out_mispredict;
  logic [31:0] out_target, out_link, redirect_pc;
  logic        redirect_valid;
  logic [31:0] taken_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .BXXOP_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .bxx_opcode(bxx_opcode), .src1(src1), .src2(src2), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_target(out_target), .out_link(out_link),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .taken_cnt(taken_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic        b, j, jr;
    logic [2:0]  op;
    logic [31:0] a, c, p, im;
    logic        pt;
    logic [31:0] ptg;
  } vec_t;

  typedef struct {
    logic        taken, mis;
    logic [31:0] tgt, link, rpc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic        head_shown = 1'b0;
  logic [31:0] m_taken = '0;
  logic [31:0] m_mis = '0;
  logic        stall_prev = 1'b0;
  logic        prev_taken, prev_mis;
  logic [31:0] prev_tgt, prev_link;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic b, input logic j, input logic jr, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] c, input logic [31:0] p,
                              input logic [31:0] im, input logic pt, input logic [31:0] ptg);
    vec_t v;
    v.b = b; v.j = j; v.jr = jr; v.op = op; v.a = a; v.c = c;
    v.p = p; v.im = im; v.pt = pt; v.ptg = ptg;
    return v;
  endfunction

  // Architectural meaning of each funct3 code, straight from the ISA
  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic cond;
    case (v.op)
      3'd0:    cond = (v.a == v.c);
      3'd1:    cond = (v.a != v.c);
      3'd2:    cond = 1'b0;
      3'd3:    cond = 1'b1;
      3'd4:    cond = ($signed(v.a) < $signed(v.c));
      3'd5:    cond = ($signed(v.a) >= $signed(v.c));
      3'd6:    cond = (v.a < v.c);
      default: cond = (v.a >= v.c);
    endcase
    e.taken = (v.j || v.jr) ? 1'b1 : (v.b ? cond : 1'b0);
    e.tgt   = v.jr ? ((v.a + v.im) & 32'hFFFF_FFFE) : (v.p + v.im);
    e.link  = v.p + 32'd4;
    e.mis   = (e.taken != v.pt) || (e.taken && (e.tgt != v.ptg));
    e.rpc   = e.taken ? e.tgt : e.link;
    return e;
  endfunction

  // Model bookkeeping on each clock edge
  always @(posedge clk) begin
    exp_t e;
    if (rst || flush) begin
      if (rst) begin
        m_taken = '0;
        m_mis   = '0;
      end
      q.delete();
      head_shown = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_taken = m_taken + 32'(e.taken);
          m_mis   = m_mis + 32'(e.mis);
        end
        head_shown = 1'b0;
      end
      if (in_valid && in_ready)
        q.push_back(model(mk(in_is_branch, in_is_jal, in_is_jalr, bxx_opcode, src1, src2,
                             pc, imm, pred_taken, pred_target)));
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    chk("taken_cnt", taken_cnt, m_taken);
    chk("mispred_cnt", mispred_cnt, m_mis);
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_taken", out_taken, prev_taken);
      chk("hold_mispredict", out_mispredict, prev_mis);
      chk("hold_target", out_target, prev_tgt);
      chk("hold_link", out_link, prev_link);
    end
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          e = q[0];
          chk("out_taken", out_taken, e.taken);
          chk("out_mispredict", out_mispredict, e.mis);
          chk("out_target", out_target, e.tgt);
          chk("out_link", out_link, e.link);
          if (!head_shown) begin
            chk("redirect_first", redirect_valid, e.mis);
            if (e.mis) begin
              chk("redirect_pc", redirect_pc, e.rpc);
              while (q.size() > 1) void'(q.pop_back());
            end
            head_shown = 1'b1;
          end else begin
            chk("redirect_repeat", redirect_valid, 0);
          end
        end
      end else begin
        chk("redirect_idle", redirect_valid, 0);
      end
      if (redirect_valid)
        chk("in_ready_redirect", in_ready, 0);
      else if (q.size() == 0)
        chk("in_ready_empty", in_ready, 1);
      else if (q.size() >= 2 && out_valid && !out_ready)
        chk("in_ready_full", in_ready, 0);
    end
    stall_prev = out_valid && !out_ready && !flush && !rst;
    prev_taken = out_taken;
    prev_mis   = out_mispredict;
    prev_tgt   = out_target;
    prev_link  = out_link;
  end

  // Present one entry until accepted; called and returns at posedge+1
  task automatic send(input vec_t v);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_is_branch = v.b; in_is_jal = v.j; in_is_jalr = v.jr;
    bxx_opcode = v.op; src1 = v.a; src2 = v.c; pc = v.p; imm = v.im;
    pred_taken = v.pt; pred_target = v.ptg;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t        tbl[11];
  logic [15:0] pat;
  exp_t        pin;

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_is_branch = 1'b0; in_is_jal = 1'b0; in_is_jalr = 1'b0; bxx_opcode = '0;
    src1 = '0; src2 = '0; pc = '0; imm = '0; pred_taken = 1'b0; pred_target = '0;

    // Literal pins of the model itself
    pin = model(mk(1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 0, 0));
    chk("pin_blt_taken", pin.taken, 1);
    pin = model(mk(1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 0, 0));
    chk("pin_bltu_taken", pin.taken, 0);
    pin = model(mk(1, 0, 0, 3'd7, 32'd0, 32'd0, 32'h0, 32'h0, 0, 0));
    chk("pin_bgeu_taken", pin.taken, 1);
    pin = model(mk(0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h200, 32'd2, 1, 32'h1000));
    chk("pin_jalr_target", pin.tgt, 32'h1002);
    chk("pin_jalr_link", pin.link, 32'h204);
    chk("pin_jalr_mis", pin.mis, 1);
    pin = model(mk(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1, 32'd4));
    chk("pin_jal_wrap_target", pin.tgt, 32'h4);
    chk("pin_jal_wrap_link", pin.link, 32'h0);
    pin = model(mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h364, 32'd0, 1, 32'h368));
    chk("pin_nonctl_mis", pin.mis, 1);
    chk("pin_nonctl_rpc", pin.rpc, 32'h368);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_lit", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // BEQ mispredicted as not-taken: latency, redirect, counter
    send(mk(1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 32'h0));
    @(negedge clk);
    chk("A_t1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("A_out_valid", out_valid, 1);
    chk("A_taken", out_taken, 1);
    chk("A_target", out_target, 32'h120);
    chk("A_mispredict", out_mispredict, 1);
    chk("A_redirect", redirect_valid, 1);
    chk("A_redirect_pc", redirect_pc, 32'h120);
    @(negedge clk);
    chk("A_redirect_once", redirect_valid, 0);
    chk("A_mispred_cnt", mispred_cnt, 1);
    @(posedge clk); #1;
    idle(2);

    // Correctly predicted compares
    send(mk(1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h140, 32'h40, 1, 32'h180));
    send(mk(1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h144, 32'h40, 0, 32'h0));
    send(mk(1, 0, 0, 3'd7, 32'd0, 32'd0, 32'h148, 32'h8, 1, 32'h150));
    idle(4);
    chk("B_taken_cnt", taken_cnt, 3);
    chk("B_mispred_cnt", mispred_cnt, 1);

    // JALR correct, then wrong target
    send(mk(0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h200, 32'd2, 1, 32'h1002));
    @(negedge clk);
    @(negedge clk);
    chk("J1_target", out_target, 32'h1002);
    chk("J1_link", out_link, 32'h204);
    chk("J1_mispredict", out_mispredict, 0);
    chk("J1_redirect", redirect_valid, 0);
    @(posedge clk); #1;
    idle(2);
    send(mk(0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h200, 32'd2, 1, 32'h1000));
    @(negedge clk);
    @(negedge clk);
    chk("J2_redirect", redirect_valid, 1);
    chk("J2_redirect_pc", redirect_pc, 32'h1002);
    @(posedge clk); #1;
    idle(3);
    chk("J_taken_cnt", taken_cnt, 5);
    chk("J_mispred_cnt", mispred_cnt, 2);

    // Stream with 3-cycle backpressure over a mispredicting entry
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(mk(1, 0, 0, 3'd0, 32'd1, 32'd1, 32'h400, 32'h8, 1, 32'h408));
        send(mk(1, 0, 0, 3'd1, 32'd7, 32'd7, 32'h404, 32'h8, 1, 32'h500));
        send(mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h408, 32'h0, 0, 32'h0));
        send(mk(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h40C, 32'h100, 1, 32'h50C));
        send(mk(1, 0, 0, 3'd5, 32'd3, 32'hFFFF_FFFE, 32'h410, 32'h10, 1, 32'h420));
      end
    join
    idle(5);
    chk("S_taken_cnt", taken_cnt, 8);
    chk("S_mispred_cnt", mispred_cnt, 3);

    // Flush with a stalled mispredict in S2 and a younger entry in S1
    out_ready = 1'b0;
    send(mk(1, 0, 0, 3'd1, 32'd3, 32'd3, 32'h600, 32'h40, 1, 32'h640));
    send(mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h604, 32'h0, 0, 32'h0));
    send(mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h608, 32'h0, 0, 32'h0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("F1_out_valid", out_valid, 0);
    chk("F1_redirect", redirect_valid, 0);
    chk("F1_taken_cnt", taken_cnt, 8);
    chk("F1_mispred_cnt", mispred_cnt, 3);
    @(posedge clk); #1;
    idle(2);

    // Flush while a mispredict sits in S1
    send(mk(1, 0, 0, 3'd0, 32'd1, 32'd2, 32'h700, 32'h80, 1, 32'h780));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("F2_out_valid", out_valid, 0);
    chk("F2_redirect", redirect_valid, 0);
    @(negedge clk);
    chk("F2_no_late_redirect", redirect_valid, 0);
    chk("F2_mispred_cnt", mispred_cnt, 3);
    @(posedge clk); #1;

    // Mixed table with a toggling out_ready pattern
    tbl[0]  = mk(1, 0, 0, 3'd1, 32'd1, 32'd2, 32'h300, 32'h10, 1, 32'h310);
    tbl[1]  = mk(1, 0, 0, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h320, 32'h10, 0, 32'h0);
    tbl[2]  = mk(1, 0, 0, 3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h340, 32'h10, 1, 32'h350);
    tbl[3]  = mk(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1, 32'h4);
    tbl[4]  = mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h360, 32'd0, 0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'h364, 32'd0, 1, 32'h368);
    tbl[6]  = mk(1, 0, 0, 3'd2, 32'd5, 32'd5, 32'h370, 32'd4, 0, 32'h0);
    tbl[7]  = mk(1, 0, 0, 3'd3, 32'd5, 32'd6, 32'h380, 32'd4, 1, 32'h384);
    tbl[8]  = mk(1, 0, 0, 3'd4, 32'd9, 32'd9, 32'h390, 32'd4, 0, 32'h0);
    tbl[9]  = mk(1, 0, 0, 3'd0, 32'd9, 32'd9, 32'h3A0, 32'h20, 1, 32'h3B0);
    tbl[10] = mk(0, 0, 1, 3'd0, 32'hFFFF_FFF0, 32'd0, 32'h3B0, 32'h13, 1, 32'h4);
    pat = 16'b1011_0111_0011_1101;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k % 16];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 11; i++) send(tbl[i]);
      end
    join
    idle(6);

    // Reset mid-operation drops everything
    send(mk(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'h800, 32'h10, 0, 32'h0));
    send(mk(1, 0, 0, 3'd0, 32'd0, 32'd1, 32'h804, 32'h10, 0, 32'h0));
    rst = 1'b1;
    @(negedge clk);
    chk("R_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("R_out_valid", out_valid, 0);
    chk("R_redirect", redirect_valid, 0);
    chk("R_taken_cnt", taken_cnt, 0);
    chk("R_mispred_cnt", mispred_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("R_post_in_ready", in_ready, 1);
    chk("R_post_out_valid", out_valid, 0);
    @(posedge clk); #1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined branch resolution unit for the NRC core. Sits in the execute stage after the register read and immediate path. It evaluates conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and JAL/JALR, computes the target and link address, and checks both against the front-end prediction. On a mispredict it issues a one-cycle redirect and keeps taken and mispredict counters. It uses a two-stage pipeline with valid/ready handshake on both sides.

## Interface
- XLEN, 32, datapath and address width
- BXXOP_W, 3, branch opcode width (RISC-V funct3 encoding)
- CNT_W, 32, statistics counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  kill all in-flight entries (higher-level pipeline flush)
- in_valid  in  1  input entry valid
- in_ready  out  1  unit can accept an entry this cycle
- in_is_branch / in_is_jal / in_is_jalr  in  1 each  entry type; at most one set; none set means non-control
- bxx_opcode  in  BXXOP_W  [2:1]: 00=eq, 10=lt signed, 11=lt unsigned; [0]=invert
- src1, src2  in  XLEN  rs1/rs2 values
- pc, imm  in  XLEN  instruction PC, sign-extended immediate
- pred_taken  in  1  front-end prediction
- pred_target  in  XLEN  front-end predicted target
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_taken, out_mispredict  out  1 each  resolved direction, mispredict flag
- out_target, out_link  out  XLEN  resolved target, pc+4
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  fetch restart address
- taken_cnt, mispred_cnt  out  CNT_W each  statistics

## Operation
- **S1 register:** captures the input when in_valid & in_ready.
  - in_ready = ~rst & ~redirect_valid & (~s1_valid | s1 advancing).
  - s1 advances when ~s2_valid | (out_valid & out_ready).
- **S1 compute (combinational):**
  - Subtract src1-src2 with XLEN+1-bit borrow.
  - eq = (diff==0).
  - ltu = borrow.
  - lt = (src1 neg & src2 non-neg) | (same sign & diff neg).
  - cond = selected compare XOR bxx_opcode[0]. Opcode [2:1]=01 selects no compare: cond=bxx_opcode[0].
- **Direction:** taken = jal|jalr ? 1 : branch ? cond : 0.
- **Target:**
  - jalr: (src1+imm) & ~1.
  - Otherwise: pc+imm.
  - All sums modulo 2^XLEN.
  - link = pc+4, wraps.
- **Mispredict:** (taken != pred_taken) | (taken & target != pred_target).
  - A non-control entry mispredicts only if pred_taken=1.
- **redirect_pc:** target if taken, else link.
- **S2 register:** holds all results; drives out_*; stalls while out_valid & ~out_ready.
- **Redirect:**
  - redirect_valid pulses exactly once per mispredicting entry, in the first cycle it is in S2, even if it stalls there.
  - In that same cycle the S1 entry (younger, wrong-path) is invalidated and no input is accepted.
- **flush:** s1_valid and s2_valid clear next cycle. flush beats capture, advance, redirect and counter updates in the same cycle. No redirect is generated for flushed entries.
- **Counters:**
  - Update on S2 retire (out_valid & out_ready & ~flush).
  - taken_cnt += out_taken; mispred_cnt += out_mispredict.
  - Wrap at 2^CNT_W.
  - Cleared only by rst, not by flush.

## Timing
- **Reset:** while rst is high, all output registers and counters are 0 and in_ready=0. After rst deasserts: out_valid=0, redirect_valid=0, redirect_pc=0, out_*=0, counters=0, in_ready=1.
- **Latency:** accepted at edge of cycle T; out_valid and redirect_valid in T+2.
- **Throughput:** one entry per cycle while out_ready=1.
- **Backpressure:**
  - out_ready=0 with S2 full: S2 holds and S1 holds.
  - in_ready drops only when S1 is full and not advancing.
  - Outputs stay stable while out_valid & ~out_ready.
- **Simultaneous events:**
  - Retire and load S2 in the same cycle is allowed.
  - rst mid-operation drops all entries with no redirect.

## Test plan
- BEQ src1=5, src2=5, pc=0x100, imm=0x20, pred_taken=0 -> T+2: out_taken=1, target=0x120, mispredict=1, one redirect pulse to 0x120, mispred_cnt=1.
- BLT src1=0xFFFFFFFF, src2=1 -> taken. BLTU same operands -> not taken. BGEU 0 vs 0 -> taken. Each has pred matching, so no redirect.
- JALR src1=0x1001, imm=2, pc=0x200, pred_taken=1, pred_target=0x1002 -> target 0x1002, link 0x204, no mispredict. Same entry with pred_target=0x1000 -> redirect 0x1002.
- Back-to-back stream with out_ready held 0 for 3 cycles -> at most 2 entries held, in_ready=0, outputs stable, no loss or duplication after release. A stalled mispredict entry pulses redirect only once.
- Mispredicted branch followed by a valid entry -> the younger entry never appears on out_valid.
- flush asserted with both stages full and S2 mispredicting -> no redirect, out_valid=0 next cycle, counters unchanged.
